// File: rtl/rst_domain_release_seq.sv
// Per-domain reset release sequencer: domain 0 on pre-release, domains 1..NUM_DOM-1 staggered after all-release.
// Optional abort counter output enabled by macro SCU_RST_SEQ_ABORT_CNT_EN.
module rst_domain_release_seq #(
  parameter int NUM_DOM = 4,
  parameter int GAP_CNT = 4
) (
  input  logic               clk_i,
  input  logic               rst_i,
  input  logic               pre_release_i,
  input  logic               all_release_i,
  input  logic [NUM_DOM-1:0] dom_mask_i,
  output logic [NUM_DOM-1:0] dom_rst_n_o,
  output logic               seq_busy_o,
  output logic               seq_done_o
`ifdef SCU_RST_SEQ_ABORT_CNT_EN
  ,
  output logic [7:0]         abort_cnt_o
`endif
);

  localparam int CNT_W = $clog2(GAP_CNT + 1);
  localparam int IDX_W = $clog2(NUM_DOM);

  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
  localparam logic [CNT_W-1:0] CNT_GAP  = CNT_W'(GAP_CNT);
  localparam logic [IDX_W-1:0] IDX_ONE  = IDX_W'(1);
  localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(NUM_DOM - 1);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_PRE  = 2'd1,
    ST_SEQ  = 2'd2,
    ST_DONE = 2'd3
  } state_t;

  state_t             state_q, state_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [IDX_W-1:0]   idx_q, idx_d;
  logic [NUM_DOM-1:0] dom_rst_n_q, dom_rst_n_d;
  logic               busy_q, busy_d;
  logic               done_q, done_d;
  logic               seq_abort_s;

  // Next-state, slot counter and per-domain release decisions; aborts take priority over sequencing.
  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    idx_d       = idx_q;
    dom_rst_n_d = dom_rst_n_q;
    seq_abort_s = 1'b0;

    case (state_q)
      ST_IDLE: begin
        dom_rst_n_d = {NUM_DOM{1'b0}};
        cnt_d       = {CNT_W{1'b0}};
        idx_d       = {IDX_W{1'b0}};
        if (pre_release_i) begin
          state_d        = ST_PRE;
          dom_rst_n_d[0] = dom_mask_i[0];
        end else begin
          state_d = ST_IDLE;
        end
      end

      ST_PRE: begin
        if (!pre_release_i) begin
          state_d     = ST_IDLE;
          dom_rst_n_d = {NUM_DOM{1'b0}};
          cnt_d       = {CNT_W{1'b0}};
          idx_d       = {IDX_W{1'b0}};
        end else if (all_release_i) begin
          state_d = ST_SEQ;
          cnt_d   = CNT_ONE;
          idx_d   = IDX_ONE;
        end else begin
          state_d = ST_PRE;
        end
      end

      ST_SEQ: begin
        if (!pre_release_i) begin
          state_d     = ST_IDLE;
          dom_rst_n_d = {NUM_DOM{1'b0}};
          cnt_d       = {CNT_W{1'b0}};
          idx_d       = {IDX_W{1'b0}};
          seq_abort_s = 1'b1;
        end else if (!all_release_i) begin
          state_d     = ST_PRE;
          dom_rst_n_d = {{(NUM_DOM-1){1'b0}}, dom_rst_n_q[0]};
          cnt_d       = {CNT_W{1'b0}};
          idx_d       = {IDX_W{1'b0}};
          seq_abort_s = 1'b1;
        end else if (cnt_q == CNT_GAP) begin
          // Slot boundary: the mask bit is sampled only here, so masked slots still take GAP_CNT cycles.
          dom_rst_n_d[idx_q] = dom_mask_i[idx_q];
          cnt_d              = CNT_ONE;
          if (idx_q == IDX_LAST) begin
            state_d = ST_DONE;
          end else begin
            idx_d = idx_q + IDX_ONE;
          end
        end else begin
          cnt_d = cnt_q + CNT_ONE;
        end
      end

      ST_DONE: begin
        if (!pre_release_i) begin
          state_d     = ST_IDLE;
          dom_rst_n_d = {NUM_DOM{1'b0}};
          cnt_d       = {CNT_W{1'b0}};
          idx_d       = {IDX_W{1'b0}};
        end else if (!all_release_i) begin
          state_d     = ST_PRE;
          dom_rst_n_d = {{(NUM_DOM-1){1'b0}}, dom_rst_n_q[0]};
          cnt_d       = {CNT_W{1'b0}};
          idx_d       = {IDX_W{1'b0}};
        end else begin
          state_d = ST_DONE;
        end
      end

      default: begin
        state_d     = ST_IDLE;
        dom_rst_n_d = {NUM_DOM{1'b0}};
        cnt_d       = {CNT_W{1'b0}};
        idx_d       = {IDX_W{1'b0}};
      end
    endcase

    busy_d = (state_d == ST_PRE) || (state_d == ST_SEQ);
    done_d = (state_d == ST_DONE);
  end

  // State and output registers.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q     <= ST_IDLE;
      cnt_q       <= {CNT_W{1'b0}};
      idx_q       <= {IDX_W{1'b0}};
      dom_rst_n_q <= {NUM_DOM{1'b0}};
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      idx_q       <= idx_d;
      dom_rst_n_q <= dom_rst_n_d;
      busy_q      <= busy_d;
      done_q      <= done_d;
    end
  end

  assign dom_rst_n_o = dom_rst_n_q;
  assign seq_busy_o  = busy_q;
  assign seq_done_o  = done_q;

`ifdef SCU_RST_SEQ_ABORT_CNT_EN
  logic [7:0] abort_cnt_q;

  // Saturating count of sequences aborted while in SEQ.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      abort_cnt_q <= 8'h00;
    end else if (seq_abort_s && (abort_cnt_q != 8'hFF)) begin
      abort_cnt_q <= abort_cnt_q + 8'h01;
    end else begin
      abort_cnt_q <= abort_cnt_q;
    end
  end

  assign abort_cnt_o = abort_cnt_q;
`else
  logic unused_abort_s;
  assign unused_abort_s = seq_abort_s;
`endif

endmodule

// File: tb/tb_rst_domain_release_seq.sv
// Directed self-checking bench for rst_domain_release_seq (NUM_DOM=4, GAP_CNT=4).
// Honours SCU_RST_SEQ_ABORT_CNT_EN when defined.
module tb_rst_domain_release_seq;

  logic       clk_i = 1'b0;
  logic       rst_i = 1'b1;
  logic       pre_release_i = 1'b0;
  logic       all_release_i = 1'b0;
  logic [3:0] dom_mask_i = 4'hF;
  logic [3:0] dom_rst_n_o;
  logic       seq_busy_o;
  logic       seq_done_o;
`ifdef SCU_RST_SEQ_ABORT_CNT_EN
  logic [7:0] abort_cnt_o;
`endif

  int n_checks = 0;
  int n_fails  = 0;
  int abort_exp = 0;

  rst_domain_release_seq #(.NUM_DOM(4), .GAP_CNT(4)) dut (
    .clk_i         (clk_i),
    .rst_i         (rst_i),
    .pre_release_i (pre_release_i),
    .all_release_i (all_release_i),
    .dom_mask_i    (dom_mask_i),
    .dom_rst_n_o   (dom_rst_n_o),
    .seq_busy_o    (seq_busy_o),
    .seq_done_o    (seq_done_o)
`ifdef SCU_RST_SEQ_ABORT_CNT_EN
    ,
    .abort_cnt_o   (abort_cnt_o)
`endif
  );

  always #5 clk_i = ~clk_i;

  task automatic step(input int n);
    repeat (n) @(posedge clk_i);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic check_all(input string tag, input logic [3:0] dom, input logic busy, input logic done);
    check({tag, "_dom"}, {28'd0, dom_rst_n_o}, {28'd0, dom});
    check({tag, "_busy"}, {31'd0, seq_busy_o}, {31'd0, busy});
    check({tag, "_done"}, {31'd0, seq_done_o}, {31'd0, done});
`ifdef SCU_RST_SEQ_ABORT_CNT_EN
    check({tag, "_abort"}, {24'd0, abort_cnt_o}, abort_exp);
`endif
  endtask

  initial begin
    // Reset for two cycles
    rst_i = 1'b1;
    step(2);
    check_all("reset", 4'b0000, 1'b0, 1'b0);
    rst_i = 1'b0;
    step(3);
    check_all("idle", 4'b0000, 1'b0, 1'b0);

    // all_release without pre_release is ignored
    all_release_i = 1'b1;
    step(2);
    check_all("all_only", 4'b0000, 1'b0, 1'b0);
    all_release_i = 1'b0;

    // Nominal sequence
    pre_release_i = 1'b1;
    step(1);
    check_all("nom_pre", 4'b0001, 1'b1, 1'b0);
    step(9);
    check_all("nom_pre_hold", 4'b0001, 1'b1, 1'b0);
    all_release_i = 1'b1;
    step(1);
    check_all("nom_seq_start", 4'b0001, 1'b1, 1'b0);
    step(3);
    check_all("nom_e23", 4'b0001, 1'b1, 1'b0);
    step(1);
    check_all("nom_e24", 4'b0011, 1'b1, 1'b0);
    step(3);
    check_all("nom_e27", 4'b0011, 1'b1, 1'b0);
    step(1);
    check_all("nom_e28", 4'b0111, 1'b1, 1'b0);
    step(3);
    check_all("nom_e31", 4'b0111, 1'b1, 1'b0);
    step(1);
    check_all("nom_e32", 4'b1111, 1'b0, 1'b1);
    dom_mask_i = 4'h0;
    step(5);
    check_all("done_hold", 4'b1111, 1'b0, 1'b1);
    dom_mask_i = 4'hF;

    // Drop from DONE: back to IDLE, not counted as a SEQ abort
    pre_release_i = 1'b0;
    all_release_i = 1'b0;
    step(1);
    check_all("done_abort", 4'b0000, 1'b0, 1'b0);

    // Masked domain 2
    dom_mask_i = 4'b1011;
    pre_release_i = 1'b1;
    step(1);
    check_all("msk_pre", 4'b0001, 1'b1, 1'b0);
    all_release_i = 1'b1;
    step(1);
    step(4);
    check_all("msk_d1", 4'b0011, 1'b1, 1'b0);
    step(4);
    check_all("msk_d2", 4'b0011, 1'b1, 1'b0);
    step(4);
    check_all("msk_d3", 4'b1011, 1'b0, 1'b1);
    pre_release_i = 1'b0;
    all_release_i = 1'b0;
    dom_mask_i = 4'hF;
    step(1);
    check_all("msk_clr", 4'b0000, 1'b0, 1'b0);

    // Simultaneous rise: PRE first, SEQ on the next edge
    pre_release_i = 1'b1;
    all_release_i = 1'b1;
    step(1);
    check_all("sim_pre", 4'b0001, 1'b1, 1'b0);
    step(1);
    step(3);
    check_all("sim_e3", 4'b0001, 1'b1, 1'b0);
    step(1);
    check_all("sim_d1", 4'b0011, 1'b1, 1'b0);
    step(2);

    // Abort mid-SEQ via pre_release drop
    pre_release_i = 1'b0;
    abort_exp++;
    step(1);
    check_all("abort_seq", 4'b0000, 1'b0, 1'b0);
    step(2);
    check_all("abort_hold", 4'b0000, 1'b0, 1'b0);

    // Re-raise: full sequence restarts from domain 0
    pre_release_i = 1'b1;
    step(1);
    check_all("rerun_pre", 4'b0001, 1'b1, 1'b0);
    step(1);
    step(4);
    check_all("rerun_d1", 4'b0011, 1'b1, 1'b0);
    step(4);
    check_all("rerun_d2", 4'b0111, 1'b1, 1'b0);
    step(2);

    // Partial abort: all_release drops, domain 0 stays released
    all_release_i = 1'b0;
    abort_exp++;
    step(1);
    check_all("part_abort", 4'b0001, 1'b1, 1'b0);
    step(3);
    check_all("part_hold", 4'b0001, 1'b1, 1'b0);
    all_release_i = 1'b1;
    step(1);
    step(3);
    check_all("part_e3", 4'b0001, 1'b1, 1'b0);
    step(1);
    check_all("part_d1", 4'b0011, 1'b1, 1'b0);

    // Domain 0 masked at pre-release
    pre_release_i = 1'b0;
    all_release_i = 1'b0;
    abort_exp++;
    step(1);
    dom_mask_i = 4'b1110;
    pre_release_i = 1'b1;
    step(1);
    check_all("msk0_pre", 4'b0000, 1'b1, 1'b0);
    dom_mask_i = 4'hF;
    all_release_i = 1'b1;
    step(5);
    check_all("msk0_d1", 4'b0010, 1'b1, 1'b0);

    // Synchronous reset mid-sequence clears everything
    rst_i = 1'b1;
    abort_exp = 0;
    step(1);
    check_all("srst_mid", 4'b0000, 1'b0, 1'b0);
    rst_i = 1'b0;
    pre_release_i = 1'b0;
    all_release_i = 1'b0;
    step(1);

`ifdef SCU_RST_SEQ_ABORT_CNT_EN
    // Saturation: 300 SEQ aborts
    for (int i = 0; i < 300; i++) begin
      pre_release_i = 1'b1;
      all_release_i = 1'b1;
      step(2);
      pre_release_i = 1'b0;
      step(1);
      if (abort_exp < 255) abort_exp++;
    end
    check_all("sat", 4'b0000, 1'b0, 1'b0);
    check("sat_ff", {24'd0, abort_cnt_o}, 32'h0000_00FF);
    rst_i = 1'b1;
    abort_exp = 0;
    step(1);
    check_all("sat_rst", 4'b0000, 1'b0, 1'b0);
    rst_i = 1'b0;
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
    $finish;
  end

endmodule
